// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the CPU data memory.
// Define DATAMEM_ARB_FIXED_PRIO_EN to give port A fixed priority on ties.
module datamem_arbiter #(
  parameter int ADDR_W = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_data,
  output logic [31:0] a_q,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_data,
  output logic [31:0] b_q,
  output logic        b_ack,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

  state_t             state, state_nxt;
  logic               grant_a, grant_b;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [31:0]        lat_data;

  // Address bits above the memory depth are intentionally ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W]};

`ifndef DATAMEM_ARB_FIXED_PRIO_EN
  logic last;
`endif

  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
`ifdef DATAMEM_ARB_FIXED_PRIO_EN
        if (a_req)      grant_a = 1'b1;
        else if (b_req) grant_b = 1'b1;
`else
        // On a tie the port that was not served last wins.
        if (a_req && (!b_req || last)) grant_a = 1'b1;
        else if (b_req)                grant_b = 1'b1;
`endif
        if (grant_a)      state_nxt = BUSY_A;
        else if (grant_b) state_nxt = BUSY_B;
      end
      BUSY_A, BUSY_B: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
`ifndef DATAMEM_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      a_ack <= (state == BUSY_A);
      b_ack <= (state == BUSY_B);
      if (state == BUSY_A) a_q <= mem_q;
      if (state == BUSY_B) b_q <= mem_q;
      if (grant_a) begin
        lat_we   <= a_we;
        lat_addr <= a_addr[ADDR_W-1:0];
        lat_data <= a_data;
`ifndef DATAMEM_ARB_FIXED_PRIO_EN
        last     <= 1'b0;
`endif
      end else if (grant_b) begin
        lat_we   <= b_we;
        lat_addr <= b_addr[ADDR_W-1:0];
        lat_data <= b_data;
`ifndef DATAMEM_ARB_FIXED_PRIO_EN
        last     <= 1'b1;
`endif
      end
    end
  end

  // Reset gating keeps an aborted write from reaching memory.
  assign mem_we   = lat_we & ~reset & (state != IDLE);
  assign mem_addr = {{(32-ADDR_W){1'b0}}, lat_addr};
  assign mem_data = lat_data;

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and sequencer placed in front of the CPU data memory (32-bit words, combinational read, synchronous write). It shares the single memory port between requester A (CPU memory stage) and requester B (DMA/debug master). Each access is a registered two-cycle transaction with a one-cycle `ack` pulse and registered read data.

## Interface
- `ADDR_W`, 7: word-address bits forwarded to memory (depth = 2^ADDR_W).
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `a_req` input 1: port A requests an access; `a_we`, `a_addr`, `a_data` must stay stable until `a_ack`.
- `a_we` input 1: 1 = write, 0 = read.
- `a_addr` input 32: word address; bits above ADDR_W are ignored.
- `a_data` input 32: write data.
- `a_q` output 32: read data, valid while `a_ack` = 1.
- `a_ack` output 1: one-cycle completion pulse.
- `b_req`, `b_we`, `b_addr`, `b_data`, `b_q`, `b_ack`: same as port A, for port B.
- `mem_addr` output 32: to memory; `{0, lat_addr[ADDR_W-1:0]}`.
- `mem_we` output 1: memory write enable.
- `mem_data` output 32: memory write data.
- `mem_q` input 32: memory read data (combinational; equals `mem_data` while `mem_we` = 1).

## Operation
- States: IDLE, BUSY_A, BUSY_B.
- IDLE: if any req, pick winner (see arbitration); latch winner's we/addr[ADDR_W-1:0]/data into lat_*; go BUSY_A or BUSY_B. No req: stay IDLE.
- BUSY_x: drive mem_addr/mem_data from lat_*; `mem_we = lat_we & ~reset`; at the closing edge capture `mem_q` into x_q, assert x_ack for the next cycle, return to IDLE.
- Outside BUSY: mem_we = 0; mem_addr/mem_data hold lat_* values.
- Arbitration (default round-robin): 1-bit `last` (0=A, 1=B). Single requester wins. If both request, the port ≠ `last` wins. `last` is updated on every grant.
- A request asserted in the cycle its own ack is high counts as a new request. This lets a port do back-to-back accesses by keeping req high and changing addr/data in the ack cycle.
- Writes: x_q returns the written data (memory bypass value).
- x_q holds its value between acks. Only the served port's q is updated.
- Reset: state→IDLE, `last`→1 (A wins the first tie), a_ack=b_ack=0, a_q=b_q=0, lat_*=0. Reset in BUSY aborts the access: no write is committed because mem_we is gated by reset, and no ack is issued.

## Timing
- Latency: req sampled at edge N (IDLE) → BUSY during cycle N..N+1 → ack high during cycle N+1..N+2.
- Throughput: one access per 2 cycles. Under continuous contention, grants alternate A,B,A,B.
- acks are mutually exclusive and never high two consecutive cycles for the same port without an intervening grant.
- Deasserting req while a transaction is BUSY has no effect: the latched access completes and acks.
- Both req in the same IDLE cycle: exactly one is granted. The loser stays pending and is granted on the next IDLE cycle (2 cycles later).

## Configuration
- `DATAMEM_ARB_FIXED_PRIO_EN` defined: port A always wins ties. `last` is not implemented, and B can starve under continuous A traffic.
- Not defined: round-robin as described above.

## Test plan
- Reset then A write addr 5 = 0xDEADBEEF: mem_we high exactly one cycle with mem_addr=5; a_ack one cycle later; a_q=0xDEADBEEF; b_ack stays 0.
- B read addr 5 after the above: b_ack on the 2nd cycle after the request edge, b_q=0xDEADBEEF; a_q unchanged.
- A and B both held high for 8 accesses (round-robin build): ack order A,B,A,B…, one ack every 2 cycles. With `DATAMEM_ARB_FIXED_PRIO_EN`: only A acks while A is held.
- a_addr=0x00000085 write 7 (ADDR_W=7): mem_addr=0x05. A read of addr 5 returns 7.
- Reset asserted during BUSY_A of a write to addr 9 = 0x1234: no mem_we edge, no ack, a later read of addr 9 returns the previous value, state IDLE after reset.
- A req held through its ack with a new addr: second grant on the ack cycle edge, with no idle cycle beyond the 2-cycle cadence.
